// File: rtl/bm_pkg.sv
// rtl/bm_pkg.sv - shared index layout, side enum and geometry helpers for the block-match result path
package bm_pkg;

    // Result index layout: {img[3:0], row[5:0], col[5:0]}
    localparam int IDX_W   = 16;
    localparam int COL_LSB = 0;
    localparam int COL_W   = 6;
    localparam int ROW_LSB = 6;
    localparam int ROW_W   = 6;
    localparam int IMG_LSB = 12;
    localparam int IMG_W   = 4;

    typedef enum logic {
        SIDE_LEFT  = 1'b0,
        SIDE_RIGHT = 1'b1
    } side_e;

    typedef struct packed {
        logic [IMG_W-1:0] img;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } blk_index_t;

    // Blocks per row: the third frame plus half of the extra centre-frame
    // blocks on its side.
    function automatic int calc_bpr(input int third_w, input int center_w,
                                    input int block_width);
        return third_w / block_width + ((center_w - third_w) / block_width) / 2;
    endfunction

    // Block rows: the last search window must fit inside the frame.
    function automatic int calc_bpc(input int third_h, input int search_blk_h,
                                    input int block_height);
        return (third_h - search_blk_h) / block_height;
    endfunction

    function automatic int calc_nblk(input int bpr, input int bpc);
        return bpr * bpc;
    endfunction

    function automatic blk_index_t unpack_blk_index(input logic [IDX_W-1:0] idx);
        blk_index_t b;
        b.img = idx[IMG_LSB +: IMG_W];
        b.row = idx[ROW_LSB +: ROW_W];
        b.col = idx[COL_LSB +: COL_W];
        return b;
    endfunction

endpackage

// File: rtl/bm_result_slot.sv
// rtl/bm_result_slot.sv - one-entry valid/ready holding register released by an external grant
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   res_valid/res_ready           upstream handshake (ready depends only on state and grant)
//   res_index/res_disp/res_sad    result fields captured on handshake
//   grant                         entry is consumed by the arbiter this cycle
//   slot_valid/slot_*             held entry
module bm_result_slot
    import bm_pkg::*;
#(
    parameter int disp_w = 6,
    parameter int sad_w  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [IDX_W-1:0]  res_index,
    input  logic [disp_w-1:0] res_disp,
    input  logic [sad_w-1:0]  res_sad,
    input  logic              grant,
    output logic              slot_valid,
    output logic [IDX_W-1:0]  slot_index,
    output logic [disp_w-1:0] slot_disp,
    output logic [sad_w-1:0]  slot_sad
);

    // A granted entry leaves this cycle, so the slot can refill in the same
    // cycle and a continuously granted side never loses throughput.
    assign res_ready = !slot_valid || grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= 1'b0;
            slot_index <= '0;
            slot_disp  <= '0;
            slot_sad   <= '0;
        end else if (res_valid && res_ready) begin
            slot_valid <= 1'b1;
            slot_index <= res_index;
            slot_disp  <= res_disp;
            slot_sad   <= res_sad;
        end else if (grant) begin
            slot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bm_result_collector.sv
// rtl/bm_result_collector.sv - arbitrates left/right block-match results into the double-buffered disparity map
//
// Ports:
//   clk, reset_n                           clock, asynchronous active-low reset
//   res_{valid,ready,index,disp,sad}_left  left engine result stream
//   res_{valid,ready,index,disp,sad}_right right engine result stream
//   map_wr_en/map_wr_addr/map_wr_data      map write port, data = {invalid, 0, disp}
//   frame_done/frame_done_img              pulse when both sides completed an image
//   err_sticky                             dropped or out-of-range result seen since reset
module bm_result_collector
    import bm_pkg::*;
#(
    parameter int third_w      = 240,
    parameter int center_w     = 304,
    parameter int third_h      = 480,
    parameter int block_width  = 16,
    parameter int block_height = 16,
    parameter int search_blk_h = 32,
    parameter int disp_w       = 6,
    parameter int sad_w        = 16,
    parameter int sad_thresh   = 2048
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              res_valid_left,
    output logic              res_ready_left,
    input  logic [15:0]       res_index_left,
    input  logic [disp_w-1:0] res_disp_left,
    input  logic [sad_w-1:0]  res_sad_left,
    input  logic              res_valid_right,
    output logic              res_ready_right,
    input  logic [15:0]       res_index_right,
    input  logic [disp_w-1:0] res_disp_right,
    input  logic [sad_w-1:0]  res_sad_right,
    output logic              map_wr_en,
    output logic [15:0]       map_wr_addr,
    output logic [disp_w+1:0] map_wr_data,
    output logic              frame_done,
    output logic [3:0]        frame_done_img,
    output logic              err_sticky
);

    localparam int BPR  = calc_bpr(third_w, center_w, block_width);
    localparam int BPC  = calc_bpc(third_h, search_blk_h, block_height);
    localparam int NBLK = calc_nblk(BPR, BPC);

    localparam logic [8:0]       N_CNT    = 9'(NBLK);
    localparam logic [15:0]      SIDE_OFS = 16'(NBLK);
    localparam logic [15:0]      IMG_OFS  = 16'(2 * NBLK);
    localparam logic [15:0]      BPR_W    = 16'(BPR);
    localparam logic [sad_w-1:0] SAD_LIM  = sad_w'(sad_thresh);

    logic              sv_l, sv_r, grant_l, grant_r;
    logic [15:0]       idx_l, idx_r;
    logic [disp_w-1:0] disp_l, disp_r;
    logic [sad_w-1:0]  sad_l, sad_r;

    bm_result_slot #(.disp_w(disp_w), .sad_w(sad_w)) u_slot_left (
        .clk        (clk),
        .reset_n    (reset_n),
        .res_valid  (res_valid_left),
        .res_ready  (res_ready_left),
        .res_index  (res_index_left),
        .res_disp   (res_disp_left),
        .res_sad    (res_sad_left),
        .grant      (grant_l),
        .slot_valid (sv_l),
        .slot_index (idx_l),
        .slot_disp  (disp_l),
        .slot_sad   (sad_l)
    );

    bm_result_slot #(.disp_w(disp_w), .sad_w(sad_w)) u_slot_right (
        .clk        (clk),
        .reset_n    (reset_n),
        .res_valid  (res_valid_right),
        .res_ready  (res_ready_right),
        .res_index  (res_index_right),
        .res_disp   (res_disp_right),
        .res_sad    (res_sad_right),
        .grant      (grant_r),
        .slot_valid (sv_r),
        .slot_index (idx_r),
        .slot_disp  (disp_r),
        .slot_sad   (sad_r)
    );

    side_e            last_grant;
    logic [3:0]       cur_img;
    logic [8:0]       cnt_l, cnt_r, nxt_l, nxt_r;

    side_e             sel_side;
    logic [15:0]       sel_index;
    logic [disp_w-1:0] sel_disp;
    logic [sad_w-1:0]  sel_sad;
    blk_index_t        blk;
    logic              any_grant, legal_pos, cnt_zero, img_ok, do_write, err_evt;
    logic              inc_l, inc_r, done;
    logic [15:0]       addr;

    // Round-robin only matters on a tie; a lone full slot is always served.
    always_comb begin
        grant_l = 1'b0;
        grant_r = 1'b0;
        if (sv_l && sv_r) begin
            if (last_grant == SIDE_RIGHT) grant_l = 1'b1;
            else                          grant_r = 1'b1;
        end else if (sv_l) begin
            grant_l = 1'b1;
        end else if (sv_r) begin
            grant_r = 1'b1;
        end
    end

    always_comb begin
        any_grant = grant_l || grant_r;
        sel_side  = grant_r ? SIDE_RIGHT : SIDE_LEFT;
        sel_index = grant_r ? idx_r  : idx_l;
        sel_disp  = grant_r ? disp_r : disp_l;
        sel_sad   = grant_r ? sad_r  : sad_l;
        blk       = unpack_blk_index(sel_index);

        legal_pos = (int'(blk.row) < BPC) && (int'(blk.col) < BPR);
        cnt_zero  = (cnt_l == 9'd0) && (cnt_r == 9'd0);
        // With nothing counted yet any image may start; otherwise it must match.
        img_ok    = cnt_zero || (blk.img == cur_img);
        do_write  = any_grant && legal_pos && img_ok;
        err_evt   = any_grant && !(legal_pos && img_ok);

        // Extra results for an already complete side are written, not counted.
        inc_l = do_write && (sel_side == SIDE_LEFT)  && (cnt_l != N_CNT);
        inc_r = do_write && (sel_side == SIDE_RIGHT) && (cnt_r != N_CNT);
        nxt_l = cnt_l + 9'(inc_l);
        nxt_r = cnt_r + 9'(inc_r);
        done  = (inc_l || inc_r) && (nxt_l == N_CNT) && (nxt_r == N_CNT);

        addr = (blk.img[0] ? IMG_OFS : 16'd0)
             + ((sel_side == SIDE_RIGHT) ? SIDE_OFS : 16'd0)
             + 16'(blk.row) * BPR_W
             + 16'(blk.col);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= SIDE_RIGHT;
            cur_img        <= '0;
            cnt_l          <= '0;
            cnt_r          <= '0;
            map_wr_en      <= 1'b0;
            map_wr_addr    <= '0;
            map_wr_data    <= '0;
            frame_done     <= 1'b0;
            frame_done_img <= '0;
            err_sticky     <= 1'b0;
        end else begin
            map_wr_en  <= do_write;
            frame_done <= done;
            if (any_grant) last_grant <= sel_side;
            if (err_evt) err_sticky <= 1'b1;
            if (do_write) begin
                map_wr_addr <= addr;
                map_wr_data <= {(sel_sad > SAD_LIM), 1'b0, sel_disp};
                if (cnt_zero) cur_img <= blk.img;
            end
            if (done) begin
                frame_done_img <= cur_img;
                cnt_l          <= '0;
                cnt_r          <= '0;
            end else begin
                cnt_l <= nxt_l;
                cnt_r <= nxt_r;
            end
        end
    end

endmodule

// File: tb/tb_bm_result_collector.sv
// tb/tb_bm_result_collector.sv - self-checking bench for bm_result_collector
module tb_bm_result_collector;

    localparam int NB = 476;
    localparam int BPR_M = 17;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        res_valid_left = 1'b0, res_valid_right = 1'b0;
    logic        res_ready_left, res_ready_right;
    logic [15:0] res_index_left = '0, res_index_right = '0;
    logic [5:0]  res_disp_left = '0, res_disp_right = '0;
    logic [15:0] res_sad_left = '0, res_sad_right = '0;
    logic        map_wr_en;
    logic [15:0] map_wr_addr;
    logic [7:0]  map_wr_data;
    logic        frame_done;
    logic [3:0]  frame_done_img;
    logic        err_sticky;

    bm_result_collector dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .res_valid_left  (res_valid_left),
        .res_ready_left  (res_ready_left),
        .res_index_left  (res_index_left),
        .res_disp_left   (res_disp_left),
        .res_sad_left    (res_sad_left),
        .res_valid_right (res_valid_right),
        .res_ready_right (res_ready_right),
        .res_index_right (res_index_right),
        .res_disp_right  (res_disp_right),
        .res_sad_right   (res_sad_right),
        .map_wr_en       (map_wr_en),
        .map_wr_addr     (map_wr_addr),
        .map_wr_data     (map_wr_data),
        .frame_done      (frame_done),
        .frame_done_img  (frame_done_img),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t wlog[$];
    int  fd_cnt = 0, fd_at = 0, fd_img = 0, fd_with_wr = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (map_wr_en) wlog.push_back('{map_wr_addr, map_wr_data});
            if (frame_done) begin
                fd_cnt++;
                fd_at = wlog.size();
                fd_img = int'(frame_done_img);
                fd_with_wr = int'(map_wr_en);
            end
        end
    end

    task automatic put(input bit side, input logic [15:0] idx, input logic [5:0] d,
                       input logic [15:0] s, input logic v);
        if (side) begin
            res_valid_right = v; res_index_right = idx; res_disp_right = d; res_sad_right = s;
        end else begin
            res_valid_left = v; res_index_left = idx; res_disp_left = d; res_sad_left = s;
        end
    endtask

    function automatic logic vld(input bit side);
        return side ? res_valid_right : res_valid_left;
    endfunction

    function automatic logic rdy(input bit side);
        return side ? res_ready_right : res_ready_left;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        put(1'b0, '0, '0, '0, 1'b0);
        put(1'b1, '0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One result on an idle collector; checks the write lands exactly two cycles after the handshake.
    task automatic send_check(input string nm, input bit side, input logic [15:0] idx,
                              input logic [5:0] d, input logic [15:0] s, input bit exp_wr,
                              input logic [15:0] exp_addr, input logic [7:0] exp_data,
                              input bit exp_err);
        @(negedge clk);
        put(side, idx, d, s, 1'b1);
        check({nm, "_ready"}, rdy(side), 1);
        @(posedge clk);
        #1 put(side, '0, '0, '0, 1'b0);
        @(negedge clk);
        check({nm, "_early_wr"}, map_wr_en, 0);
        @(negedge clk);
        check({nm, "_wr"}, map_wr_en, exp_wr);
        if (exp_wr) begin
            check({nm, "_addr"}, map_wr_addr, exp_addr);
            check({nm, "_data"}, map_wr_data, exp_data);
        end
        check({nm, "_err"}, err_sticky, exp_err);
    endtask

    typedef struct {
        bit          side;
        logic [3:0]  img;
        logic [5:0]  row;
        logic [5:0]  col;
        logic [5:0]  disp;
        logic [15:0] sad;
        bit          exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        bit          exp_err;
    } vec_t;
    vec_t vt[8];

    logic [5:0]  disp_tab[2][NB];
    logic [15:0] sad_tab[2][NB];
    int sent_l, sent_r;

    task automatic drive_frame(input bit side, output int sent);
        int i = 0;
        int cyc = 0;
        bit acc;
        while (i < NB && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (!vld(side) && $urandom_range(0, 3) != 0)
                put(side, {4'd2, 6'(i / BPR_M), 6'(i % BPR_M)}, disp_tab[side][i],
                    sad_tab[side][i], 1'b1);
            acc = vld(side) && rdy(side);
            @(posedge clk);
            if (acc) begin
                i++;
                #1 put(side, '0, '0, '0, 1'b0);
            end
        end
        sent = i;
    endtask

    initial begin
        #900000;
        total++;
        bad++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        int li, ri, rl_cnt, rr_cnt, kl, kr, side_w, k;
        logic [7:0] exp_d;

        // side, img, row, col, disp, sad, wr, addr, data, err
        vt[0] = '{1'b0, 4'd1, 6'd2,  6'd3,  6'd5,  16'd100,  1'b1, 16'd989,  8'h05, 1'b0};
        vt[1] = '{1'b1, 4'd1, 6'd2,  6'd3,  6'd5,  16'd3000, 1'b1, 16'd1465, 8'h85, 1'b0};
        vt[2] = '{1'b0, 4'd1, 6'd27, 6'd16, 6'd63, 16'd2048, 1'b1, 16'd1427, 8'h3F, 1'b0};
        vt[3] = '{1'b1, 4'd1, 6'd0,  6'd0,  6'd0,  16'd2049, 1'b1, 16'd1428, 8'h80, 1'b0};
        vt[4] = '{1'b0, 4'd1, 6'd2,  6'd17, 6'd1,  16'd1,    1'b0, 16'd0,    8'h00, 1'b1};
        vt[5] = '{1'b1, 4'd1, 6'd28, 6'd0,  6'd1,  16'd1,    1'b0, 16'd0,    8'h00, 1'b1};
        vt[6] = '{1'b0, 4'd0, 6'd1,  6'd1,  6'd1,  16'd1,    1'b0, 16'd0,    8'h00, 1'b1};
        vt[7] = '{1'b1, 4'd1, 6'd1,  6'd1,  6'd9,  16'd5,    1'b1, 16'd1446, 8'h09, 1'b1};

        // reset state
        do_reset();
        @(negedge clk);
        check("rst_wr_en", map_wr_en, 0);
        check("rst_addr", map_wr_addr, 0);
        check("rst_data", map_wr_data, 0);
        check("rst_fd", frame_done, 0);
        check("rst_fd_img", frame_done_img, 0);
        check("rst_err", err_sticky, 0);
        check("rst_ready_l", res_ready_left, 1);
        check("rst_ready_r", res_ready_right, 1);

        // directed vector table
        for (int i = 0; i < 8; i++)
            send_check($sformatf("v%0d", i), vt[i].side, {vt[i].img, vt[i].row, vt[i].col},
                       vt[i].disp, vt[i].sad, vt[i].exp_wr, vt[i].exp_addr, vt[i].exp_data,
                       vt[i].exp_err);

        // contention: both sides offer every cycle for 10 cycles
        do_reset();
        @(posedge clk);
        wlog.delete();
        li = 0; ri = 0; rl_cnt = 0; rr_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            bit al, ar;
            @(negedge clk);
            put(1'b0, {4'd0, 6'd1, 6'(li)}, 6'(li), 16'd10, 1'b1);
            put(1'b1, {4'd0, 6'd1, 6'(ri)}, 6'(ri), 16'd10, 1'b1);
            al = res_ready_left;
            ar = res_ready_right;
            if (c >= 1 && c <= 8) begin
                rl_cnt += int'(al);
                rr_cnt += int'(ar);
            end
            @(posedge clk);
            if (al) li++;
            if (ar) ri++;
        end
        #1 put(1'b0, '0, '0, '0, 1'b0);
        put(1'b1, '0, '0, '0, 1'b0);
        repeat (6) @(negedge clk);
        check("cont_ready_l_duty", rl_cnt, 4);
        check("cont_ready_r_duty", rr_cnt, 4);
        check("cont_accepted", li + ri, 11);
        check("cont_writes", wlog.size(), li + ri);
        kl = 0; kr = 0;
        foreach (wlog[w]) begin
            side_w = (wlog[w].addr >= 16'(NB)) ? 1 : 0;
            check($sformatf("cont_order%0d", w), side_w, w % 2);
            k = side_w ? kr : kl;
            check($sformatf("cont_addr%0d", w), wlog[w].addr, side_w * NB + BPR_M + k);
            check($sformatf("cont_data%0d", w), wlog[w].data, k);
            if (side_w) kr++; else kl++;
        end
        check("cont_err", err_sticky, 0);

        // reset in the middle of a contended stream
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            put(1'b0, {4'd4, 6'd0, 6'(c)}, 6'(c), 16'd1, 1'b1);
            put(1'b1, {4'd4, 6'd0, 6'(c)}, 6'(c), 16'd1, 1'b1);
        end
        @(negedge clk);
        check("mid_pre_wr", map_wr_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_wr_en", map_wr_en, 0);
        check("mid_addr", map_wr_addr, 0);
        check("mid_data", map_wr_data, 0);
        check("mid_ready_l", res_ready_left, 1);
        check("mid_ready_r", res_ready_right, 1);
        put(1'b0, '0, '0, '0, 1'b0);
        put(1'b1, '0, '0, '0, 1'b0);
        wlog.delete();
        @(negedge clk);
        reset_n = 1'b1;
        send_check("mid_after", 1'b0, {4'd4, 6'd5, 6'd6}, 6'd7, 16'd9, 1'b1, 16'd91, 8'h07, 1'b0);
        repeat (4) @(negedge clk);
        check("mid_no_stale", wlog.size(), 1);

        // full frame, img 2, random pacing and data, reference model in arrays
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < NB; i++) begin
                disp_tab[s][i] = 6'($urandom_range(0, 63));
                sad_tab[s][i]  = 16'($urandom_range(0, 4095));
            end
        do_reset();
        @(posedge clk);
        wlog.delete();
        fd_cnt = 0; fd_at = 0; fd_img = 0; fd_with_wr = 0;
        fork
            drive_frame(1'b0, sent_l);
            drive_frame(1'b1, sent_r);
        join
        repeat (6) @(negedge clk);
        check("frm_sent_l", sent_l, NB);
        check("frm_sent_r", sent_r, NB);
        check("frm_writes", wlog.size(), 2 * NB);
        check("frm_fd_count", fd_cnt, 1);
        check("frm_fd_at", fd_at, 2 * NB);
        check("frm_fd_img", fd_img, 2);
        check("frm_fd_with_wr", fd_with_wr, 1);
        check("frm_err", err_sticky, 0);
        kl = 0; kr = 0;
        foreach (wlog[w]) begin
            side_w = (wlog[w].addr >= 16'(NB)) ? 1 : 0;
            k = side_w ? kr : kl;
            if (k < NB) begin
                exp_d = {(sad_tab[side_w][k] > 16'd2048), 1'b0, disp_tab[side_w][k]};
                check($sformatf("frm_addr%0d", w), wlog[w].addr, side_w * NB + k);
                check($sformatf("frm_data%0d", w), wlog[w].data, exp_d);
            end
            if (side_w) kr++; else kl++;
        end
        // counters cleared: a new image is adopted without error
        send_check("frm_next_img", 1'b0, {4'd5, 6'd0, 6'd0}, 6'd3, 16'd0, 1'b1, 16'd952, 8'h03,
                   1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
